// File: rtl/alu_exec_unit.sv
// Execute-stage unit: ALU-control decode, registered single-cycle ALU and a
// shift-add multiplier behind valid/ready handshakes on both sides.
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int FUNCT_W = 4,
    parameter int MUL_EN  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         ALUOp,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic [3:0]         alu_ctrl,
    output logic               illegal,
    output logic               busy
);
    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] CNT_INIT = SW'(WIDTH - 1);

    localparam logic [3:0] C_AND = 4'b0000, C_OR  = 4'b0001, C_ADD = 4'b0010,
                           C_XOR = 4'b0011, C_SLL = 4'b0100, C_SRL = 4'b0101,
                           C_SUB = 4'b0110, C_SLT = 4'b0111, C_MUL = 4'b1000,
                           C_ILL = 4'b1111;

    typedef enum logic {IDLE, MUL} state_t;
    state_t state, state_next;

    logic [3:0]       dec_ctrl;
    logic             dec_illegal;
    logic             hi_bad;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] mcand, mplier, acc, acc_next;
    logic [SW-1:0]    cnt;
    logic             accept, is_mul;

    // Funct bits above [3:0] only exist for wider encodings; any set bit is illegal.
    generate
        if (FUNCT_W > 4) begin : g_hi
            assign hi_bad = |funct[FUNCT_W-1:4];
        end else begin : g_nohi
            assign hi_bad = 1'b0;
        end
    endgenerate

    always_comb begin
        dec_ctrl    = C_ILL;
        dec_illegal = 1'b1;
        case (ALUOp)
            2'b00: begin dec_ctrl = C_ADD; dec_illegal = 1'b0; end
            2'b01: begin dec_ctrl = C_SUB; dec_illegal = 1'b0; end
            2'b11: begin dec_ctrl = C_AND; dec_illegal = 1'b0; end
            default: begin
                if (!hi_bad) begin
                    dec_illegal = 1'b0;
                    case (funct[3:0])
                        4'b0000: dec_ctrl = C_ADD;
                        4'b1000: dec_ctrl = C_SUB;
                        4'b0110: dec_ctrl = C_AND;
                        4'b0111: dec_ctrl = C_OR;
                        4'b0100: dec_ctrl = C_XOR;
                        4'b0001: dec_ctrl = C_SLL;
                        4'b0101: dec_ctrl = C_SRL;
                        4'b0010: dec_ctrl = C_SLT;
                        4'b1001: begin
                            if (MUL_EN != 0) dec_ctrl = C_MUL;
                            else             dec_illegal = 1'b1;
                        end
                        default: dec_illegal = 1'b1;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (dec_ctrl)
            C_ADD: alu_res = op_a + op_b;
            C_SUB: alu_res = op_a - op_b;
            C_AND: alu_res = op_a & op_b;
            C_OR:  alu_res = op_a | op_b;
            C_XOR: alu_res = op_a ^ op_b;
            C_SLL: alu_res = op_a << op_b[SW-1:0];
            C_SRL: alu_res = op_a >> op_b[SW-1:0];
            C_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default: alu_res = '0;
        endcase
    end

    assign in_ready = !rst && (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mul   = (dec_ctrl == C_MUL);
    assign acc_next = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && is_mul) state_next = MUL;
            MUL:  if (cnt == '0)        state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= '0;
            zero      <= 1'b0;
            alu_ctrl  <= 4'b0000;
            illegal   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else if (state == IDLE) begin
            if (accept && is_mul) begin
                mcand     <= op_a;
                mplier    <= op_b;
                acc       <= '0;
                cnt       <= CNT_INIT;
                busy      <= 1'b1;
                out_valid <= 1'b0;
            end else if (accept) begin
                result    <= alu_res;
                zero      <= (alu_res == '0);
                alu_ctrl  <= dec_ctrl;
                illegal   <= dec_illegal;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end else begin
            // One shift-add step per cycle; the last step's sum goes straight out.
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
            if (cnt == '0) begin
                result    <= acc_next;
                zero      <= (acc_next == '0);
                alu_ctrl  <= C_MUL;
                illegal   <= 1'b0;
                out_valid <= 1'b1;
                busy      <= 1'b0;
            end
        end
    end
endmodule
